// File: rtl/toggle2pulse_array.sv
// toggle2pulse_array: multi-channel toggle-to-pulse converter.
// Each channel turns every level change on its toggle input into a one-cycle
// pulse and counts it in a per-channel pending counter. A round-robin picker
// feeds a single registered valid/ready event port.
// Optional feature: define TOGGLE2PULSE_SYNC_EN to insert a SYNC-stage
// synchronizer in front of every channel (for asynchronous toggle sources).
// Without it the toggle inputs are assumed to be in the clk domain already.
//
// Event port handshake: evt_valid/evt_chan come from registers. An event is
// transferred on a rising clk edge where evt_valid & evt_ready. While
// evt_valid is high and evt_ready is low, evt_chan is held stable and the
// presented event stays owned by the port. The register reloads whenever it
// is empty or its current event is being accepted.
module toggle2pulse_array #(
    parameter  int N    = 4,
    parameter  int SYNC = 2,
    parameter  int CW   = 3,
    localparam int CHW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [N-1:0]   in,
    output logic [N-1:0]   out,
    output logic           evt_valid,
    output logic [CHW-1:0] evt_chan,
    input  logic           evt_ready,
    output logic [N-1:0]   overflow,
    input  logic           clr_overflow
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N-1:0]          level;
    logic [N-1:0]          prev_q;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]          overflow_q, overflow_d;
    logic [N-1:0]          ovf_set;
    logic                  evt_valid_q, evt_valid_d;
    logic [CHW-1:0]        evt_chan_q, evt_chan_d;
    logic [CHW-1:0]        rr_q, rr_d;
    logic                  load;
    logic                  found;
    logic [CHW-1:0]        sel;
    logic                  take;

`ifdef TOGGLE2PULSE_SYNC_EN
    logic [SYNC-1:0][N-1:0] sync_q;

    // Shift every toggle input through its synchronizer chain
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], in};
        end
    end

    assign level = sync_q[SYNC-1];
`else
    assign level = in;
`endif

    // Remember the last observed level so a change shows up as a pulse
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev_q <= '0;
        end else begin
            prev_q <= level;
        end
    end

    assign out = level ^ prev_q;

    // The output register may take a new event when empty or being drained
    assign load = !evt_valid_q || evt_ready;
    assign take = load && found;

    // Round-robin search starting just after the last loaded channel
    always_comb begin
        logic [CHW-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = CHW'((int'(rr_q) + k) % N);
            if (!found && (cnt_q[idx] != '0)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Pending counters: count new pulses, give one up when loaded, saturate
    always_comb begin
        logic loaded_i;
        cnt_d    = cnt_q;
        ovf_set  = '0;
        loaded_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            loaded_i = take && (sel == CHW'(i));
            if (out[i] && !loaded_i) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (!out[i] && loaded_i) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Sticky drop flags; a new drop wins over a clear in the same cycle
    always_comb begin
        overflow_d = (overflow_q & ~{N{clr_overflow}}) | ovf_set;
    end

    // Output register and round-robin pointer next state
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_chan_d  = evt_chan_q;
        rr_d        = rr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_chan_d = sel;
                rr_d       = sel;
            end
        end
    end

    // State registers; the pointer resets to the last channel so channel 0 wins first
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q       <= '0;
            overflow_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            rr_q        <= CHW'(N - 1);
        end else begin
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign overflow  = overflow_q;

endmodule
